// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the highway/farm-road intersection controller:
//   - state_t   : controller phases
//   - LIGHT_*   : 2-bit lamp driver encodings
//   - COUNT_W   : width of the shared dwell counter
//   - last_tick : converts a dwell length in ticks into the count value on
//                 which that dwell ends (dwell N exits when count == N-1)
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int COUNT_W = 7;

    // ARH/ARF are the all-red clearance phases before highway/farm green.
    typedef enum logic [2:0] {
        ARH   = 3'd0,
        HG    = 3'd1,
        HY    = 3'd2,
        ARF   = 3'd3,
        FG    = 3'd4,
        FY    = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [1:0] LIGHT_RED = 2'b00;
    localparam logic [1:0] LIGHT_YEL = 2'b01;
    localparam logic [1:0] LIGHT_GRN = 2'b10;

    function automatic logic [COUNT_W-1:0] last_tick(input int dwell);
        return COUNT_W'(dwell - 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for signals that are asynchronous to clk. The output
// lags the input by two rising edges. Reusable for any asynchronous input.
// Ports:
//   clk    in  1      destination clock
//   reset  in  1      asynchronous, active-low reset (clears both stages)
//   d_i    in  WIDTH  asynchronous input
//   q_o    out WIDTH  synchronised output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
// Sequencing stage of the highway/farm-road intersection controller. Reads the
// dwell count from the shared cycle counter and decides when each phase ends;
// it requests a counter clear on every phase change so that each new phase
// starts at count == 0.
// Ports:
//   clk         in  1  system clock
//   reset       in  1  asynchronous, active-low reset
//   count       in  7  dwell count from the cycle counter
//   car_sensor  in  1  farm-road vehicle present (asynchronous to clk)
//   flash_req   in  1  maintenance flash request (synchronous to clk)
//   clear       out 1  zero the counter on the next rising edge
//   hwy_light   out 2  highway lamp: 00 red, 01 yellow, 10 green
//   farm_light  out 2  farm lamp, same encoding
// -----------------------------------------------------------------------------
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int HWY_GREEN_MIN  = 64,
    parameter int FARM_GREEN_MAX = 40,
    parameter int YELLOW_TIME    = 8,
    parameter int ALL_RED_TIME   = 2,
    parameter int BLINK_BIT      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count,
    input  logic               car_sensor,
    input  logic               flash_req,
    output logic               clear,
    output logic [1:0]         hwy_light,
    output logic [1:0]         farm_light
);

    // Dwell parameters are compared against a 7-bit count, so they must fit.
    localparam bit PARAMS_OK =
        (HWY_GREEN_MIN  >= 1) && (HWY_GREEN_MIN  <= 127) &&
        (FARM_GREEN_MAX >= 1) && (FARM_GREEN_MAX <= 127) &&
        (YELLOW_TIME    >= 1) && (YELLOW_TIME    <= 127) &&
        (ALL_RED_TIME   >= 1) && (ALL_RED_TIME   <= 127) &&
        (BLINK_BIT      >= 0) && (BLINK_BIT      <  COUNT_W);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("traffic_light_fsm: dwell parameters must be 1..127 and BLINK_BIT 0..6");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] HG_LAST  = last_tick(HWY_GREEN_MIN);
    localparam logic [COUNT_W-1:0] FG_LAST  = last_tick(FARM_GREEN_MAX);
    localparam logic [COUNT_W-1:0] YEL_LAST = last_tick(YELLOW_TIME);
    localparam logic [COUNT_W-1:0] AR_LAST  = last_tick(ALL_RED_TIME);

    state_t state_q;
    state_t state_d;
    logic   min_done_q;
    logic   min_done_d;
    logic   car_s;
    logic   hg_min_hit;
    logic   blink;

    // ------------------------------------------------------------------
    // car_sensor comes from an unrelated domain; only its synchronised
    // copy may steer the FSM.
    // ------------------------------------------------------------------
    sync_2ff #(
        .WIDTH (1)
    ) u_car_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (car_sensor),
        .q_o   (car_s)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARH;
            min_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_done_q <= min_done_d;
        end
    end

    assign hg_min_hit = (count == HG_LAST);
    assign blink      = count[BLINK_BIT];

    // ------------------------------------------------------------------
    // Next-state and output decode
    // flash_req is checked first in every branch so it wins over car_s
    // and over dwell timeouts. Timed states only divert to FLASH once
    // their own dwell has completed, so a green always passes through
    // its yellow before flashing.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        min_done_d = min_done_q;
        hwy_light  = LIGHT_RED;
        farm_light = LIGHT_RED;

        case (state_q)
            ARH: begin
                if (count == AR_LAST) begin
                    state_d = flash_req ? FLASH : HG;
                end
            end

            HG: begin
                hwy_light = LIGHT_GRN;
                // min_done latches the minimum-green point; count may wrap
                // afterwards while HG waits for a car, which is harmless.
                if (hg_min_hit) begin
                    min_done_d = 1'b1;
                end
                // The min match and a waiting car on the same cycle collapse
                // into one transition because both feed a single condition.
                if (flash_req || ((min_done_q || hg_min_hit) && car_s)) begin
                    state_d    = HY;
                    min_done_d = 1'b0;
                end
            end

            HY: begin
                hwy_light = LIGHT_YEL;
                if (count == YEL_LAST) begin
                    state_d = flash_req ? FLASH : ARF;
                end
            end

            ARF: begin
                if (count == AR_LAST) begin
                    state_d = flash_req ? FLASH : FG;
                end
            end

            FG: begin
                farm_light = LIGHT_GRN;
                // Leaves as soon as the farm road empties, so FG may last a
                // single cycle if no car is seen on entry.
                if (flash_req || !car_s || (count == FG_LAST)) begin
                    state_d = FY;
                end
            end

            FY: begin
                farm_light = LIGHT_YEL;
                if (count == YEL_LAST) begin
                    state_d = flash_req ? FLASH : ARH;
                end
            end

            FLASH: begin
                // Roads blink in antiphase, driven by one count bit.
                hwy_light  = blink ? LIGHT_YEL : LIGHT_RED;
                farm_light = blink ? LIGHT_RED : LIGHT_YEL;
                if (!flash_req) begin
                    state_d = ARH;
                end
            end

            default: begin
                // Unused encoding: fall back to the all-red start phase.
                state_d    = ARH;
                min_done_d = 1'b0;
            end
        endcase
    end

    // Mealy clear: high only when the state changes this edge, so the
    // counter starts every phase at zero. Gated by reset because the
    // counter shares the reset net and must not see a stray clear.
    assign clear = reset && (state_d != state_q);

endmodule
